// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//  Shared encodings for the MUL/DIV + HI/LO sequencer:
//  request op codes, ALU control codes and FSM state encoding.
package muldiv_pkg;

  // Request op codes (Op input)
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // ALU control codes; AND is the neutral code driven while idle
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_MUL = 4'h3;
  localparam logic [3:0] ALU_DIV = 4'h4;

  // Sequencer states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_WAIT = 2'd1;
  localparam logic [1:0] ST_DIV_WAIT = 2'd2;

endpackage

// File: rtl/muldiv_settle_counter.sv
// muldiv_settle_counter
//  Down-counter timing how long the ALU inputs have been held stable.
//  Ports:
//    clk      in  clock, rising edge
//    rst_n    in  asynchronous active-low reset (count -> 0)
//    load     in  load load_val (has priority over dec)
//    load_val in  value to load (settle cycles - 1)
//    dec      in  decrement by one
//    zero     out count equals zero
module muldiv_settle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/muldiv_hilo_sequencer.sv
// muldiv_hilo_sequencer
//  Sequences MULT/DIV through the gate-level ALU and owns the HI/LO pair.
//  Operands are registered onto AluA/AluB with the ALU code held for a
//  fixed settle count, then High/Low are captured into HI/LO.
//  MTHI/MTLO write HI/LO directly; MFHI/MFLO reads stall while busy.
//  Ports:
//    Clk, Reset_n             clock / async active-low reset
//    Start, Op, A, B          request strobe, op code, operands
//    Busy, Done, DivZero      status (Done/DivZero are 1-cycle pulses)
//    AluA, AluB, AluControl   registered ALU drive
//    AluHigh, AluLow          ALU results
//    ReadEn, ReadSel          HI/LO read request (ReadSel: 0 HI, 1 LO)
//    ReadData, ReadStall      read data (combinational) and stall flag
module muldiv_hilo_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [3:0]  AluControl,
  input  logic [31:0] AluHigh,
  input  logic [31:0] AluLow,
  input  logic        ReadEn,
  input  logic        ReadSel,
  output logic [31:0] ReadData,
  output logic        ReadStall
);

  logic [1:0]  state_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] alu_a_reg, alu_b_reg;
  logic [3:0]  alu_ctrl_reg;
  logic        done_reg, divzero_reg;

  logic        idle;
  logic        start_mul, start_div;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  assign idle      = (state_reg == ST_IDLE);
  assign start_mul = idle && Start && (Op == OP_MULT);
  // A divide by zero never reaches the ALU; it completes immediately.
  assign start_div = idle && Start && (Op == OP_DIV) && (B != 32'd0);

  assign cnt_load = start_mul || start_div;
  assign cnt_val  = start_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
  assign cnt_dec  = !idle && !cnt_zero;

  muldiv_settle_counter #(
    .CNT_W(CNT_W)
  ) u_settle (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      alu_a_reg    <= 32'd0;
      alu_b_reg    <= 32'd0;
      alu_ctrl_reg <= ALU_AND;
      done_reg     <= 1'b0;
      divzero_reg  <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      divzero_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT: begin
                alu_a_reg    <= A;
                alu_b_reg    <= B;
                alu_ctrl_reg <= ALU_MUL;
                state_reg    <= ST_MUL_WAIT;
              end
              OP_DIV: begin
                if (B == 32'd0) begin
                  done_reg    <= 1'b1;
                  divzero_reg <= 1'b1;
                end else begin
                  alu_a_reg    <= A;
                  alu_b_reg    <= B;
                  alu_ctrl_reg <= ALU_DIV;
                  state_reg    <= ST_DIV_WAIT;
                end
              end
              OP_MTHI: begin
                hi_reg   <= A;
                done_reg <= 1'b1;
              end
              default: begin  // OP_MTLO
                lo_reg   <= A;
                done_reg <= 1'b1;
              end
            endcase
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_zero) begin
            hi_reg       <= AluHigh;
            lo_reg       <= AluLow;
            alu_ctrl_reg <= ALU_AND;
            done_reg     <= 1'b1;
            state_reg    <= ST_IDLE;
          end
        end
        ST_DIV_WAIT: begin
          if (cnt_zero) begin
            // ALU High carries the quotient, Low the remainder.
            lo_reg       <= AluHigh;
            hi_reg       <= AluLow;
            alu_ctrl_reg <= ALU_AND;
            done_reg     <= 1'b1;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Busy       = !idle;
  assign Done       = done_reg;
  assign DivZero    = divzero_reg;
  assign AluA       = alu_a_reg;
  assign AluB       = alu_b_reg;
  assign AluControl = alu_ctrl_reg;
  assign ReadData   = ReadSel ? lo_reg : hi_reg;
  assign ReadStall  = ReadEn && !idle;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
module tb_muldiv_hilo_sequencer;

  localparam logic [1:0] T_MULT = 2'b00;
  localparam logic [1:0] T_DIV  = 2'b01;
  localparam logic [1:0] T_MTHI = 2'b10;
  localparam logic [1:0] T_MTLO = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] AluA, AluB;
  logic [3:0]  AluControl;
  logic [31:0] AluHigh, AluLow;
  logic        ReadEn, ReadSel;
  logic [31:0] ReadData;
  logic        ReadStall;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 Clk = ~Clk;

  muldiv_hilo_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero),
    .AluA(AluA), .AluB(AluB), .AluControl(AluControl),
    .AluHigh(AluHigh), .AluLow(AluLow),
    .ReadEn(ReadEn), .ReadSel(ReadSel), .ReadData(ReadData), .ReadStall(ReadStall)
  );

  // Behavioural ALU: MUL gives the 64-bit product, DIV gives quotient/remainder.
  logic [63:0] alu_prod;
  always_comb begin
    alu_prod = {32'd0, AluA} * {32'd0, AluB};
    AluHigh  = 32'd0;
    AluLow   = 32'd0;
    if (AluControl == 4'h3) begin
      AluHigh = alu_prod[63:32];
      AluLow  = alu_prod[31:0];
    end else if (AluControl == 4'h4 && AluB != 32'd0) begin
      AluHigh = AluA / AluB;
      AluLow  = AluA % AluB;
    end
  end

  task automatic check_hilo(input string name);
    ReadSel = 1'b0;
    #1;
    n_tests++;
    if (ReadData !== exp_hi) begin
      n_fail++;
      $display("FAIL %s hi: got %h expected %h", name, ReadData, exp_hi);
    end
    ReadSel = 1'b1;
    #1;
    n_tests++;
    if (ReadData !== exp_lo) begin
      n_fail++;
      $display("FAIL %s lo: got %h expected %h", name, ReadData, exp_lo);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({Busy, Done, DivZero, ReadStall} !== 4'b0 || AluA !== 32'd0 || AluB !== 32'd0 ||
        AluControl !== 4'h0) begin
      n_fail++;
      $display("FAIL %s outputs: got busy=%b done=%b dz=%b stall=%b a=%h b=%h ctrl=%h expected all 0",
               name, Busy, Done, DivZero, ReadStall, AluA, AluB, AluControl);
    end
  endtask

  // Issue one request, follow it to Done, check timing, drive and results.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ren, input logic poke, input string name);
    int n_exp, lat, busy_cnt;
    logic dz_exp;
    logic [3:0] code_exp;
    logic [63:0] prod;
    n_exp    = (op == T_MULT) ? 4 : ((op == T_DIV && b != 32'd0) ? 8 : 0);
    dz_exp   = (op == T_DIV && b == 32'd0);
    code_exp = (op == T_MULT) ? 4'h3 : 4'h4;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; ReadEn = ren;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!Done && lat <= 20) begin
      if (Busy) busy_cnt++;
      n_tests++;
      if (AluA !== a || AluB !== b || AluControl !== code_exp || ReadStall !== ren) begin
        n_fail++;
        $display("FAIL %s hold@%0d: got a=%h b=%h ctrl=%h stall=%b expected a=%h b=%h ctrl=%h stall=%b",
                 name, lat, AluA, AluB, AluControl, ReadStall, a, b, code_exp, ren);
      end
      // Requests while busy must be ignored (MTHI of a different value).
      Start = poke && (lat < 4);
      Op = T_MTHI;
      A = ~a;
      @(posedge Clk);
      #1;
      lat++;
    end
    Start = 1'b0;
    n_tests++;
    if (lat !== n_exp || busy_cnt !== n_exp) begin
      n_fail++;
      $display("FAIL %s latency: got lat=%0d busy=%0d expected %0d", name, lat, busy_cnt, n_exp);
    end
    n_tests++;
    if (Done !== 1'b1 || DivZero !== dz_exp || Busy !== 1'b0 || ReadStall !== 1'b0 ||
        AluControl !== 4'h0) begin
      n_fail++;
      $display("FAIL %s done: got done=%b dz=%b busy=%b stall=%b ctrl=%h expected 1 %b 0 0 0",
               name, Done, DivZero, Busy, ReadStall, AluControl, dz_exp);
    end
    case (op)
      T_MULT: begin
        prod = {32'd0, a} * {32'd0, b};
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
      end
      T_DIV: if (b != 32'd0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      T_MTHI: exp_hi = a;
      default: exp_lo = a;
    endcase
    check_hilo(name);
    $display("[TB] %s op=%0d a=%h b=%h lat=%0d hi=%h lo=%h", name, op, a, b, lat, exp_hi, exp_lo);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0; ReadEn = 1'b0; ReadSel = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    check_hilo("reset");
  endtask

  task automatic test_mult();
    run_op(T_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, "mult_dir");
    n_tests++;
    if (exp_hi !== 32'd1 || exp_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL mult_ref: got %h_%h expected 1_0", exp_hi, exp_lo);
    end
  endtask

  task automatic test_div();
    run_op(T_DIV, 32'd100, 32'd7, 1'b0, 1'b1, "div_dir");
  endtask

  task automatic test_divzero();
    run_op(T_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0, 1'b0, "dz_sethi");
    run_op(T_MTLO, 32'hAAAA_AAAA, 32'd0, 1'b0, 1'b0, "dz_setlo");
    run_op(T_DIV, 32'd5, 32'd0, 1'b0, 1'b0, "div_zero");
  endtask

  task automatic test_back_to_back();
    run_op(T_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "b2b_mthi");
    run_op(T_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0, "b2b_mtlo");
  endtask

  task automatic test_read_stall();
    run_op(T_MULT, $urandom, $urandom, 1'b1, 1'b0, "read_stall");
    ReadEn = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge Clk);
    Start = 1'b1; Op = T_DIV; A = 32'd1000; B = 32'd3;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check_all_zero("reset_mid");
    check_hilo("reset_mid");
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(T_MULT, 32'd12345, 32'd6789, 1'b0, 1'b0, "post_reset_mult");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_back_to_back();
    test_read_stall();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
